// File: rtl/fetch_unit_pkg.sv
// Shared fetch-unit types and defaults.
// Address width, reset/vector constants, event codes, state bundle.
package fetch_unit_pkg;

  localparam int ADDR_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t RESET_PC_DEF   = 16'h0001;
  localparam addr_t IRQ_VECTOR_DEF = 16'h0000;
  localparam addr_t HALT_WORD_DEF  = 16'hFFFF;

  typedef enum logic [2:0] {
    EV_ADV,
    EV_STALL,
    EV_HOLD,
    EV_HALT,
    EV_IRQ,
    EV_RETI,
    EV_REDIR
  } fetch_ev_e;

  typedef struct packed {
    addr_t fetch_pc;
    addr_t resp_pc;
    logic  resp_valid;
    logic  halted;
  } fetch_st_t;

endpackage

// File: rtl/fetch_unit_pc_mux.sv
// Per-cycle event priority, memory address mux and next fetch state.
// Purely combinational; the top only registers what this produces.
module fetch_unit_pc_mux
  import fetch_unit_pkg::*;
#(
  parameter addr_t IRQ_VECTOR = IRQ_VECTOR_DEF,
  parameter addr_t HALT_WORD  = HALT_WORD_DEF
) (
  input  fetch_st_t cur,
  input  addr_t     epc,
  input  logic      in_irq,
  input  addr_t     instr,
  input  logic      stall,
  input  logic      redirect_valid,
  input  addr_t     redirect_target,
  input  logic      reti,
  input  logic      irq,
  output addr_t     pc,
  output fetch_st_t nxt,
  output fetch_ev_e ev
);

  logic  vld;
  logic  irq_en;
  logic  hi;
  addr_t tgt;

  assign vld    = cur.resp_valid & ~cur.halted;
  assign irq_en = irq & ~in_irq;
  assign hi     = redirect_valid | reti | irq_en;

  // Conditions are made mutually exclusive to encode the priority
  always_comb begin
    ev = EV_ADV;
    unique case (1'b1)
      redirect_valid:
        ev = EV_REDIR;
      reti & ~redirect_valid:
        ev = EV_RETI;
      irq_en & ~redirect_valid & ~reti:
        ev = EV_IRQ;
      ~hi & cur.halted:
        ev = EV_HOLD;
      ~hi & vld & stall:
        ev = EV_STALL;
      ~hi & vld & ~stall & (instr == HALT_WORD):
        ev = EV_HALT;
      default:
        ev = EV_ADV;
    endcase
  end

  always_comb begin
    tgt = redirect_target;
    unique case (ev)
      EV_RETI: tgt = epc;
      EV_IRQ:  tgt = IRQ_VECTOR;
      default: tgt = redirect_target;
    endcase
  end

  always_comb begin
    nxt = cur;
    pc  = cur.fetch_pc;
    unique case (ev)
      EV_REDIR, EV_RETI, EV_IRQ: begin
        pc             = tgt;
        nxt.resp_pc    = tgt;
        nxt.resp_valid = 1'b1;
        nxt.fetch_pc   = tgt + addr_t'(1);
        nxt.halted     = 1'b0;
      end
      EV_STALL: begin
        // re-read the held word so INSTR stays stable
        pc = cur.resp_pc;
      end
      EV_HOLD: begin
        pc = cur.fetch_pc;
      end
      EV_HALT: begin
        nxt.halted     = 1'b1;
        nxt.resp_valid = 1'b0;
      end
      EV_ADV: begin
        nxt.resp_pc    = cur.fetch_pc;
        nxt.resp_valid = 1'b1;
        nxt.fetch_pc   = cur.fetch_pc + addr_t'(1);
      end
      default: begin
        pc = cur.fetch_pc;
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end with stall, redirect, irq and halt.
// Memory is synchronous: INSTR answers the PC of the previous edge.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter addr_t RESET_PC   = RESET_PC_DEF,
  parameter addr_t IRQ_VECTOR = IRQ_VECTOR_DEF,
  parameter addr_t HALT_WORD  = HALT_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] PC,
  input  logic [15:0] INSTR,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  input  logic        reti,
  input  logic        irq,
  output logic        irq_ack,
  output logic [15:0] instr_out,
  output logic        instr_valid,
  output logic [15:0] instr_pc,
  output logic [15:0] epc,
  output logic        in_irq,
  output logic        halted
);

  fetch_st_t st;
  fetch_st_t nxt;
  fetch_ev_e ev;
  addr_t     pc_mux;

  fetch_unit_pc_mux #(
    .IRQ_VECTOR (IRQ_VECTOR),
    .HALT_WORD  (HALT_WORD)
  ) u_mux (
    .cur             (st),
    .epc             (epc),
    .in_irq          (in_irq),
    .instr           (INSTR),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .reti            (reti),
    .irq             (irq),
    .pc              (pc_mux),
    .nxt             (nxt),
    .ev              (ev)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st.fetch_pc   <= RESET_PC;
      st.resp_pc    <= '0;
      st.resp_valid <= 1'b0;
      st.halted     <= 1'b0;
      epc           <= '0;
      in_irq        <= 1'b0;
    end else begin
      st <= nxt;
      if (ev == EV_IRQ) begin
        // resume at the word being presented, else the next fetch
        epc    <= instr_valid ? st.resp_pc : st.fetch_pc;
        in_irq <= 1'b1;
      end else if (ev == EV_RETI) begin
        in_irq <= 1'b0;
      end
    end
  end

  assign PC          = pc_mux;
  assign irq_ack     = ~rst & (ev == EV_IRQ);
  assign instr_out   = INSTR;
  assign instr_valid = st.resp_valid & ~st.halted;
  assign instr_pc    = st.resp_pc;
  assign halted      = st.halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit over a synchronous memory model.
// Default fill is addr+16'h1000; word 6 is patched to HALT for one test.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] PC;
  logic [15:0] INSTR;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        reti;
  logic        irq;
  logic        irq_ack;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic [15:0] instr_pc;
  logic [15:0] epc;
  logic        in_irq;
  logic        halted;

  logic [15:0] mem [0:65535];

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .PC              (PC),
    .INSTR           (INSTR),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .reti            (reti),
    .irq             (irq),
    .irq_ack         (irq_ack),
    .instr_out       (instr_out),
    .instr_valid     (instr_valid),
    .instr_pc        (instr_pc),
    .epc             (epc),
    .in_irq          (in_irq),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) INSTR <= mem[PC];

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    n_fail++;
    $error("FAIL timeout");
    $finish;
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i + 16'h1000);
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 16'h0000;
    reti = 1'b0;
    irq = 1'b0;

    tick();
    tick();
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_ipc", instr_pc, 16'h0000);
    chk("rst_epc", epc, 16'h0000);
    chk("rst_inirq", in_irq, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_ack", irq_ack, 1'b0);
    chk("rst_pc", PC, 16'h0001);
    rst = 1'b0;
    #1;
    chk("c1_valid", instr_valid, 1'b0);
    chk("c1_pc", PC, 16'h0001);

    tick();
    chk("run1_valid", instr_valid, 1'b1);
    chk("run1_ipc", instr_pc, 16'h0001);
    chk("run1_pc", PC, 16'h0002);
    chk("run1_out", instr_out, 16'h1001);
    tick();
    chk("run2_ipc", instr_pc, 16'h0002);
    chk("run2_pc", PC, 16'h0003);
    tick();
    chk("run3_ipc", instr_pc, 16'h0003);
    chk("run3_pc", PC, 16'h0004);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_pc", PC, 16'h0003);
      chk("stall_out", instr_out, 16'h1003);
      chk("stall_ipc", instr_pc, 16'h0003);
      chk("stall_valid", instr_valid, 1'b1);
      tick();
    end
    stall = 1'b0;
    #1;
    chk("rel_ipc", instr_pc, 16'h0003);
    chk("rel_pc", PC, 16'h0004);
    tick();
    chk("rel4_ipc", instr_pc, 16'h0004);
    tick();
    chk("rel5_ipc", instr_pc, 16'h0005);
    chk("rel5_pc", PC, 16'h0006);

    redirect_valid = 1'b1;
    redirect_target = 16'h0040;
    stall = 1'b1;
    #1;
    chk("redir_pc", PC, 16'h0040);
    tick();
    redirect_valid = 1'b0;
    stall = 1'b0;
    #1;
    chk("redir_ipc", instr_pc, 16'h0040);
    chk("redir_valid", instr_valid, 1'b1);
    chk("redir_out", instr_out, 16'h1040);
    chk("redir_next_pc", PC, 16'h0041);

    redirect_valid = 1'b1;
    redirect_target = 16'h0006;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("to6_ipc", instr_pc, 16'h0006);
    tick();
    chk("to7_ipc", instr_pc, 16'h0007);

    irq = 1'b1;
    #1;
    chk("irq_ack", irq_ack, 1'b1);
    chk("irq_pc", PC, 16'h0000);
    tick();
    chk("irq_ack_off", irq_ack, 1'b0);
    chk("irq_epc", epc, 16'h0007);
    chk("irq_inirq", in_irq, 1'b1);
    chk("irq_ipc", instr_pc, 16'h0000);
    chk("irq_out", instr_out, 16'h1000);
    chk("irq_next_pc", PC, 16'h0001);
    tick();
    chk("irq2_ack", irq_ack, 1'b0);
    chk("irq2_ipc", instr_pc, 16'h0001);
    chk("irq2_epc", epc, 16'h0007);
    irq = 1'b0;
    reti = 1'b1;
    #1;
    chk("reti_pc", PC, 16'h0007);
    tick();
    reti = 1'b0;
    #1;
    chk("reti_ipc", instr_pc, 16'h0007);
    chk("reti_inirq", in_irq, 1'b0);
    chk("reti_valid", instr_valid, 1'b1);

    mem[6] = 16'hFFFF;
    redirect_valid = 1'b1;
    redirect_target = 16'h0004;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("h4_ipc", instr_pc, 16'h0004);
    tick();
    chk("h5_ipc", instr_pc, 16'h0005);
    tick();
    chk("h6_ipc", instr_pc, 16'h0006);
    chk("h6_out", instr_out, 16'hFFFF);
    chk("h6_valid", instr_valid, 1'b1);
    chk("h6_halted", halted, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_halted", halted, 1'b1);
      chk("halt_valid", instr_valid, 1'b0);
      chk("halt_pc", PC, 16'h0007);
    end
    irq = 1'b1;
    #1;
    chk("wake_ack", irq_ack, 1'b1);
    chk("wake_pc", PC, 16'h0000);
    tick();
    irq = 1'b0;
    #1;
    chk("wake_epc", epc, 16'h0007);
    chk("wake_halted", halted, 1'b0);
    chk("wake_ipc", instr_pc, 16'h0000);
    chk("wake_valid", instr_valid, 1'b1);
    chk("wake_inirq", in_irq, 1'b1);
    reti = 1'b1;
    tick();
    reti = 1'b0;
    #1;
    chk("wret_ipc", instr_pc, 16'h0007);
    mem[6] = 16'h1006;

    redirect_valid = 1'b1;
    redirect_target = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("wrap0_ipc", instr_pc, 16'hFFFE);
    chk("wrap0_out", instr_out, 16'h0FFE);
    chk("wrap0_pc", PC, 16'hFFFF);
    tick();
    chk("wrap1_ipc", instr_pc, 16'hFFFF);
    chk("wrap1_out", instr_out, 16'h0FFF);
    chk("wrap1_valid", instr_valid, 1'b1);
    chk("wrap1_pc", PC, 16'h0000);
    tick();
    chk("wrap2_ipc", instr_pc, 16'h0000);
    chk("wrap2_out", instr_out, 16'h1000);

    rst = 1'b1;
    tick();
    chk("mrst_valid", instr_valid, 1'b0);
    chk("mrst_ipc", instr_pc, 16'h0000);
    chk("mrst_epc", epc, 16'h0000);
    chk("mrst_inirq", in_irq, 1'b0);
    chk("mrst_halted", halted, 1'b0);
    chk("mrst_pc", PC, 16'h0001);
    rst = 1'b0;
    tick();
    chk("mrst_run_ipc", instr_pc, 16'h0001);
    chk("mrst_run_valid", instr_valid, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
